// File: rtl/fare_accum_ctrl.sv
// fare_accum_ctrl: taxi fare sequencer sharing one BCD adder between distance and waiting ticks; NIGHT_SURCHARGE_EN adds a night double-add
module fare_accum_ctrl #(
  parameter logic [15:0] BASE_FARE  = 16'h0800,
  parameter logic [7:0]  BASE_UNITS = 8'd30,
  parameter logic [15:0] DIST_RATE  = 16'h0020,
  parameter logic [15:0] WAIT_RATE  = 16'h0010
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        dist_tick,
  input  logic        wait_tick,
`ifdef NIGHT_SURCHARGE_EN
  input  logic        night,
`endif
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  output logic        add_cin,
  input  logic [15:0] add_sum,
  input  logic        add_cout,
  output logic [15:0] fare,
  output logic        busy,
  output logic        ovf,
  output logic        done
);
`ifdef NIGHT_SURCHARGE_EN
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, NIGHT2} state_t;
  logic [15:0] rate_q;
  logic        ret_drain;
`else
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
`endif
  state_t      state, next_state;
  logic [7:0]  free_cnt;
  logic [3:0]  dist_pend, wait_pend;
  logic        grant, grant_dist, grant_wait, accept, dist_inc, wait_inc;

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= next_state;

  // next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:  next_state = start ? RUN : IDLE;
`ifdef NIGHT_SURCHARGE_EN
      RUN:    next_state = (grant && night && !add_cout) ? NIGHT2 : stop ? DRAIN : RUN;
      DRAIN:  next_state = (grant && night && !add_cout) ? NIGHT2 : grant ? DRAIN : IDLE;
      NIGHT2: next_state = (ret_drain || stop) ? DRAIN : RUN;
`else
      RUN:   next_state = stop ? DRAIN : RUN;
      DRAIN: next_state = grant ? DRAIN : IDLE;
`endif
      default: next_state = IDLE;
    endcase
  end

  // adder arbitration, tick acceptance and status outputs
  always_comb begin
    grant_dist = (state == RUN || state == DRAIN) && !ovf && dist_pend != 4'd0;
    grant_wait = (state == RUN || state == DRAIN) && !ovf && dist_pend == 4'd0 && wait_pend != 4'd0;
`ifdef NIGHT_SURCHARGE_EN
    grant  = grant_dist || grant_wait || state == NIGHT2;
    add_b  = state == NIGHT2 ? rate_q : grant_dist ? DIST_RATE : grant_wait ? WAIT_RATE : 16'h0000;
    accept = !ovf && (state == RUN || (state == NIGHT2 && !ret_drain));
`else
    grant  = grant_dist || grant_wait;
    add_b  = grant_dist ? DIST_RATE : grant_wait ? WAIT_RATE : 16'h0000;
    accept = !ovf && state == RUN;
`endif
    dist_inc = accept && dist_tick && free_cnt >= BASE_UNITS && (dist_pend != 4'hf || grant_dist);
    wait_inc = accept && wait_tick && (wait_pend != 4'hf || grant_wait);
    busy     = state != IDLE;
    add_a    = fare;
    add_cin  = 1'b0;
  end

  // fare, overflow, pending counters and done pulse
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      fare      <= 16'h0000;
      ovf       <= 1'b0;
      done      <= 1'b0;
      free_cnt  <= 8'd0;
      dist_pend <= 4'd0;
      wait_pend <= 4'd0;
`ifdef NIGHT_SURCHARGE_EN
      rate_q    <= 16'h0000;
      ret_drain <= 1'b0;
`endif
    end else begin
      done <= state == DRAIN && next_state == IDLE;
      if (state == IDLE && start) begin
        fare      <= BASE_FARE;
        ovf       <= 1'b0;
        free_cnt  <= 8'd0;
        dist_pend <= 4'd0;
        wait_pend <= 4'd0;
      end else if (grant && add_cout) begin
        fare      <= 16'h9999;
        ovf       <= 1'b1;
        dist_pend <= 4'd0;
        wait_pend <= 4'd0;
      end else begin
        if (grant) fare <= add_sum;
        if (accept && dist_tick && free_cnt < BASE_UNITS) free_cnt <= free_cnt + 8'd1;
        dist_pend <= dist_pend + {3'b000, dist_inc} - {3'b000, grant_dist};
        wait_pend <= wait_pend + {3'b000, wait_inc} - {3'b000, grant_wait};
      end
`ifdef NIGHT_SURCHARGE_EN
      if (state != NIGHT2) begin
        rate_q    <= add_b;
        ret_drain <= state == DRAIN || stop;
      end
`endif
    end
endmodule
